// File: rtl/p3_pkg.sv
// Shared lab package: FSM state encoding, requester count and the even-bit
// switch parity function used by several board blocks.
package p3_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic even_parity8(input logic [7:0] v);
    return v[0] ^ v[2] ^ v[4] ^ v[6];
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick: scans ptr, ptr+1, ... mod 4 and returns the
// first pending request as a one-hot vector plus its index.
module rr_arbiter4
  import p3_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_vld
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset back to ptr so the closest pending one wins.
  always_comb begin
    idx     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        win_idx = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    if (win_vld) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/parity_btn_arbiter.sv
// Shares the even-bit switch parity checker among four push buttons: presses
// are synchronised, queued, granted round-robin and shown on the LEDs.
module parity_btn_arbiter
  import p3_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          sw,
  input  logic [NUM_REQ-1:0]  btn,
  output logic [1:0]          led,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  state_t state, state_nxt;

  logic [NUM_REQ-1:0] sync1, sync2, sync3;
  logic [NUM_REQ-1:0] rise, pend, pend_clr;
  logic [NUM_REQ-1:0] win_oh, gnt_q;
  logic [IDX_W-1:0]   ptr, win_idx, gidx;
  logic               win_vld;
  logic [7:0]         swcap;
  logic [CW-1:0]      cnt;
  logic               par;

  // Two flops for metastability, a third as the previous value for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  rr_arbiter4 u_arb (
    .req     (pend),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Clear on GRANT exit; a rise in the same cycle re-arms the bit.
  assign pend_clr = (state == GRANT) ? gnt_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~pend_clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = GRANT;
      GRANT:   state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      gidx  <= '0;
      ptr   <= '0;
      swcap <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          gnt_q <= win_oh;
          gidx  <= win_idx;
          ptr   <= win_idx + IDX_W'(1);
        end
        GRANT: begin
          swcap <= sw;
          cnt   <= CNT_LOAD;
        end
        HOLD: if (cnt != '0) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Result is only qualified for requesters 0 and 2 (even index).
  assign par = even_parity8(swcap);

  always_comb begin
    led  = '0;
    gnt  = '0;
    busy = (state != IDLE);
    if (state != IDLE) gnt = gnt_q;
    if (state == HOLD) led = {par & ~gidx[0], par};
  end

endmodule
